muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer with architectural HI/LO registers for the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU from the EX stage and runs a radix-2 shift-add or restoring-divide loop over WIDTH cycles. It drives a stall request into the hazard logic while busy, and serves MFHI/MFLO/MTHI/MTLO.

---
 rtl/muldiv_seq.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer with architectural HI/LO registers.
// Optional macro MULDIV_EARLY_EXIT_EN: multiplies finish once the remaining multiplier bits are zero.
module muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wd,
    input  logic             rd_hilo,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StPrep, StRun, StFix} state_e;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic is_div, is_sgn, a_neg, b_neg, early;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign is_div = op_q[1];
    assign is_sgn = ~op_q[0];
    assign a_neg  = is_sgn & opa_q[WIDTH-1];
    assign b_neg  = is_sgn & opb_q[WIDTH-1];
    assign a_mag  = a_neg ? -opa_q : opa_q;
    assign b_mag  = b_neg ? -opb_q : opb_q;

    // Multiply step: accumulate into the upper half, then shift the whole product right.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opa_q & {WIDTH{opb_q[0]}}};

    // Restoring divide step: upper half is the partial remainder, lower half dividend/quotient.
    logic [WIDTH:0] rem_sh, div_diff;
    logic           div_ok;
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = rem_sh - {1'b0, opb_q};
    assign div_ok   = ~div_diff[WIDTH];

    logic [2*WIDTH-1:0] prod_raw, prod;
    logic [WIDTH-1:0]   quo, rem;

`ifdef MULDIV_EARLY_EXIT_EN
    assign early    = ~is_div & (opb_q[WIDTH-1:1] == '0);
    // An early exit leaves the product short of its final right shifts.
    assign prod_raw = acc_q >> (LAST - cnt_q);
`else
    assign early    = 1'b0;
    assign prod_raw = acc_q;
`endif

    assign prod = neg_q ? -prod_raw : prod_raw;
    assign quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    op_d    = op;
                    opa_d   = a;
                    opb_d   = b;
                    state_d = StPrep;
                end else if (!start) begin
                    if (mthi) hi_d = wd;
                    if (mtlo) lo_d = wd;
                end
            end
            StPrep: begin
                cnt_d  = '0;
                neg_d  = a_neg ^ b_neg;
                rneg_d = a_neg;
                dz_d   = is_div && (opb_q == '0);
                if (is_div && (opb_q == '0)) begin
                    // Keep the raw dividend: it is returned in HI unchanged.
                    state_d = StFix;
                end else begin
                    opa_d   = a_mag;
                    opb_d   = b_mag;
                    acc_d   = is_div ? {{WIDTH{1'b0}}, a_mag} : '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (is_div) begin
                    acc_d = {(div_ok ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                             acc_q[WIDTH-2:0], div_ok};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    opb_d = opb_q >> 1;
                end
                if ((cnt_q == LAST) || early) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StFix: begin
                if (dz_q) begin
                    hi_d = opa_q;
                    lo_d = '1;
                end else if (is_div) begin
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (flush && (state_q != StIdle)) begin
            state_d = StIdle;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q != StIdle);
    assign stall = busy && (start || rd_hilo || mthi || mtlo);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed and random ops against an arithmetic model.
module tb_muldiv_seq;
    localparam int unsigned WIDTH = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b, wd;
    logic        mthi, mtlo, rd_hilo, flush;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .wd      (wd),
        .rd_hilo (rd_hilo),
        .flush   (flush),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference results straight from 64-bit integer arithmetic.
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] eh, output logic [31:0] el,
                                  output int ebusy);
        longint          sx, sy, q, r;
        longint unsigned ux, uy, uq, ur;
        logic [63:0]     p;
        logic [31:0]     mag;
        int              top;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = 64'(x);
        uy = 64'(y);
        ebusy = WIDTH + 2;
        p = '0;
        case (o)
            2'b00: p = sx * sy;
            2'b01: p = ux * uy;
            2'b10: begin
                if (y == 0) p = {x, 32'hFFFF_FFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 0) p = {x, 32'hFFFF_FFFF};
                else begin
                    uq = ux / uy;
                    ur = ux % uy;
                    p = {ur[31:0], uq[31:0]};
                end
            end
        endcase
        if (o[1] && (y == 0)) ebusy = 2;
`ifdef MULDIV_EARLY_EXIT_EN
        if (!o[1]) begin
            mag = ((o == 2'b00) && y[31]) ? -y : y;
            top = 0;
            for (int i = 0; i < 32; i++) if (mag[i]) top = i + 1;
            ebusy = 2 + ((top < 1) ? 1 : top);
        end
`endif
        eh = p[63:32];
        el = p[31:0];
    endfunction

    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit hazard);
        logic [31:0] eh, el, h0, l0;
        int          eb, cyc, dones;
        bit          held;
        model(o, x, y, eh, el, eb);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        h0 = hi; l0 = lo; held = 1'b1; cyc = 0; dones = 0;
        while (busy && (cyc < 200)) begin
            cyc++;
            if (done) dones++;
            if ((hi !== h0) || (lo !== l0)) held = 1'b0;
            if (hazard && (cyc == 2)) begin
                #1 chk({tag, "_stall_idle"}, 64'(stall), 64'd0);
            end
            if (hazard && (cyc == 3)) begin
                rd_hilo = 1'b1;
                #1 chk({tag, "_stall_rd"}, 64'(stall), 64'd1);
            end
            if (hazard && (cyc == 4)) begin
                rd_hilo = 1'b0; start = 1'b1; op = 2'b11; a = 32'hDEAD; b = 32'h3;
                mtlo = 1'b1; wd = 32'h5555;
                #1 chk({tag, "_stall_st"}, 64'(stall), 64'd1);
            end
            if (hazard && (cyc == 5)) begin
                start = 1'b0; mtlo = 1'b0;
            end
            @(negedge clk);
        end
        chk({tag, "_busy_len"}, 64'(cyc), 64'(eb));
        chk({tag, "_early_done"}, 64'(dones), 64'd0);
        chk({tag, "_held"}, 64'(held), 64'd1);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_hi"}, 64'(hi), 64'(eh));
        chk({tag, "_lo"}, 64'(lo), 64'(el));
        @(negedge clk);
        chk({tag, "_done_off"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [31:0] h0, l0, rx, ry;
        logic [1:0]  ro;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; wd = '0;
        mthi = 1'b0; mtlo = 1'b0; rd_hilo = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        reset = 1'b0;

        do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_max_hi_c", 64'(hi), 64'hFFFF_FFFE);
        chk("multu_max_lo_c", 64'(lo), 64'h1);
        do_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
        chk("mult_neg_lo_c", 64'(lo), 64'hFFFF_FFEB);
        do_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_neg_lo_c", 64'(lo), 64'hFFFF_FFFD);
        do_op("divu", 2'b11, 32'd100, 32'd7, 1'b0);
        do_op("div_zero", 2'b10, 32'd5, 32'd0, 1'b0);
        do_op("divu_zero", 2'b11, 32'h8000_0001, 32'd0, 1'b0);
        do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf_lo_c", 64'(lo), 64'h8000_0000);
        do_op("multu_small", 2'b01, 32'd5, 32'd3, 1'b0);
        do_op("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
        do_op("hazard", 2'b01, 32'h1357_9BDF, 32'hFFFF_FFFF, 1'b1);

        // Moves in IDLE
        @(negedge clk);
        h0 = hi; mtlo = 1'b1; wd = 32'h1234;
        @(negedge clk);
        mtlo = 1'b0;
        chk("mtlo_lo", 64'(lo), 64'h1234);
        chk("mtlo_hi_kept", 64'(hi), 64'(h0));
        mthi = 1'b1; mtlo = 1'b1; wd = 32'hA5A5_0F0F;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        chk("mtboth_hi", 64'(hi), 64'hA5A5_0F0F);
        chk("mtboth_lo", 64'(lo), 64'hA5A5_0F0F);

        // Flush at RUN counter 10
        start = 1'b1; op = 2'b01; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        h0 = hi; l0 = lo;
        repeat (11) @(negedge clk);
        chk("flush_busy_pre", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_done", 64'(done), 64'd0);
        chk("flush_hi", 64'(hi), 64'(h0));
        chk("flush_lo", 64'(lo), 64'(l0));
        @(negedge clk);
        chk("flush_done2", 64'(done), 64'd0);

        // Flush in IDLE beats start but leaves moves alone
        start = 1'b1; flush = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        chk("flush_start_busy", 64'(busy), 64'd0);
        mthi = 1'b1; wd = 32'h0BAD_F00D;
        @(negedge clk);
        mthi = 1'b0; flush = 1'b0;
        chk("flush_idle_mthi", 64'(hi), 64'h0BAD_F00D);

        // Reset mid-RUN
        start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstrun_busy", 64'(busy), 64'd0);
        chk("rstrun_hi", 64'(hi), 64'd0);
        chk("rstrun_lo", 64'(lo), 64'd0);
        chk("rstrun_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            case ($urandom_range(0, 7))
                0:       ry = 32'd0;
                1, 2:    ry = 32'($urandom_range(0, 255));
                3:       begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
                default: ry = $urandom;
            endcase
            do_op("rand", ro, rx, ry, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
